register_file_v2: RTL and testbench

//  Parametrised integer register file for the RV32 core: XLEN/NUM_REGS configurable (RV32I/RV32E),
//  two combinational read ports, one write port with optional write-to-read bypass.

---
 rtl/register_file_v2_pkg.sv | 7 +
 rtl/register_file_v2_if.sv | 19 +
 rtl/register_file_v2_dbg_ctrl.sv | 73 +++++++
 rtl/register_file_v2.sv | 49 ++++
 tb/tb_register_file_v2.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_v2_pkg.sv
// register_file_v2_pkg: shared FSM state type, debug-bus mode codes and default debug base address
package register_file_v2_pkg;
  typedef enum logic [1:0] {IDLE, WR_PEND, CLEAR, ACK} state_t;
  localparam logic [1:0] DBG_MODE_READ = 2'b01;
  localparam logic [1:0] DBG_MODE_WRITE = 2'b10;
  localparam logic [31:0] DBG_BASE_DEFAULT = 32'h4100;
endpackage

// File: rtl/register_file_v2_if.sv
// register_file_v2_if: core read/write ports, debug-bus slave and clear handshake of the register file
interface register_file_v2_if #(parameter int XLEN = 32);
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic [XLEN-1:0] rd_data, rs1_data, rs2_data;
  logic rd_we;
  logic [31:0] dbg_addr;
  logic [XLEN-1:0] dbg_wdata, dbg_rdata;
  logic [1:0] dbg_mode;
  logic dbg_sel, dbg_ack;
  logic clr_req, busy;
  modport master (
    output rs1_addr, rs2_addr, rd_addr, rd_data, rd_we, dbg_addr, dbg_wdata, dbg_mode, dbg_sel, clr_req,
    input rs1_data, rs2_data, dbg_rdata, dbg_ack, busy
  );
  modport slave (
    input rs1_addr, rs2_addr, rd_addr, rd_data, rd_we, dbg_addr, dbg_wdata, dbg_mode, dbg_sel, clr_req,
    output rs1_data, rs2_data, dbg_rdata, dbg_ack, busy
  );
endinterface

// File: rtl/register_file_v2_dbg_ctrl.sv
// register_file_v2_dbg_ctrl: debug-bus FSM, address decode and clear sequencer driving the storage write port
module register_file_v2_dbg_ctrl
  import register_file_v2_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter logic [31:0] DBG_BASE = DBG_BASE_DEFAULT,
  parameter int AW = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  input  logic [1:0]      dbg_mode,
  input  logic            dbg_sel,
  input  logic            rd_we,
  input  logic            clr_req,
  input  logic [XLEN-1:0] rd_val,
  output logic [AW-1:0]   dbg_idx,
  output logic            w_en,
  output logic [AW-1:0]   w_idx,
  output logic [XLEN-1:0] w_data,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            dbg_ack,
  output logic            busy
);
  state_t state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [31:0] off;
  logic valid, rd_req, wr_req, dbg_w;
  // Addresses below the base wrap to a huge offset and so decode as invalid
  assign off = dbg_addr - DBG_BASE;
  assign valid = off[1:0] == 2'b00 && off[31:2] < 30'(NUM_REGS);
  assign dbg_idx = off[AW+1:2];
  assign rd_req = state == IDLE && dbg_sel && dbg_mode == DBG_MODE_READ;
  assign wr_req = state == IDLE && dbg_sel && dbg_mode == DBG_MODE_WRITE;
  assign dbg_w = (wr_req || state == WR_PEND) && !rd_we;
  assign busy = state == CLEAR;
  assign dbg_ack = state == ACK;
  assign w_en = busy || (dbg_w && valid && dbg_idx != '0);
  assign w_idx = busy ? cnt : dbg_idx;
  assign w_data = busy ? '0 : dbg_wdata;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE:
        if (rd_req) state_nx = ACK;
        else if (wr_req) state_nx = rd_we ? WR_PEND : ACK;
        else if (clr_req) begin
          state_nx = CLEAR;
          cnt_nx = AW'(1);
        end
      WR_PEND: state_nx = rd_we ? WR_PEND : ACK;
      ACK: state_nx = IDLE;
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        state_nx = cnt == AW'(NUM_REGS - 1) ? IDLE : CLEAR;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (rd_req) dbg_rdata <= valid ? rd_val : '0;
    end
endmodule

// File: rtl/register_file_v2.sv
// register_file_v2: RV32 integer register file with write bypass, debug-bus slave and clear engine
module register_file_v2
  import register_file_v2_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS = 1,
  parameter logic [31:0] DBG_BASE = DBG_BASE_DEFAULT
) (
  input logic clk,
  input logic reset,
  register_file_v2_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  logic [XLEN-1:0] regs [NUM_REGS];
  logic core_we, w_en;
  logic [AW-1:0] w_idx, dbg_idx;
  logic [XLEN-1:0] w_data;
  register_file_v2_dbg_ctrl #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .DBG_BASE(DBG_BASE)) u_ctrl (
    .clk(clk),
    .reset(reset),
    .dbg_addr(bus.dbg_addr),
    .dbg_wdata(bus.dbg_wdata),
    .dbg_mode(bus.dbg_mode),
    .dbg_sel(bus.dbg_sel),
    .rd_we(bus.rd_we),
    .clr_req(bus.clr_req),
    .rd_val(regs[dbg_idx]),
    .dbg_idx(dbg_idx),
    .w_en(w_en),
    .w_idx(w_idx),
    .w_data(w_data),
    .dbg_rdata(bus.dbg_rdata),
    .dbg_ack(bus.dbg_ack),
    .busy(bus.busy)
  );
  // Debug writes only commit with rd_we low and clear stalls the core, so the two write sources never collide
  assign core_we = bus.rd_we && bus.rd_addr != '0 && 32'(bus.rd_addr) < NUM_REGS && !bus.busy;
  assign bus.rs1_data = (bus.rs1_addr == '0 || 32'(bus.rs1_addr) >= NUM_REGS) ? '0 :
                        (BYPASS != 0 && core_we && bus.rd_addr == bus.rs1_addr) ? bus.rd_data :
                        regs[bus.rs1_addr[AW-1:0]];
  assign bus.rs2_data = (bus.rs2_addr == '0 || 32'(bus.rs2_addr) >= NUM_REGS) ? '0 :
                        (BYPASS != 0 && core_we && bus.rd_addr == bus.rs2_addr) ? bus.rd_data :
                        regs[bus.rs2_addr[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (core_we) regs[bus.rd_addr[AW-1:0]] <= bus.rd_data;
    else if (w_en) regs[w_idx] <= w_data;
endmodule

// File: tb/tb_register_file_v2.sv
// tb_register_file_v2: randomized self-checking bench for register_file_v2 (32-reg bypass and 16-reg no-bypass builds)
module tb_register_file_v2;
  import register_file_v2_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] m [32];
  always #5 clk = ~clk;
  register_file_v2_if #(.XLEN(32)) bus_a ();
  register_file_v2_if #(.XLEN(32)) bus_b ();
  register_file_v2 #(.XLEN(32), .NUM_REGS(32), .BYPASS(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  register_file_v2 #(.XLEN(32), .NUM_REGS(16), .BYPASS(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus_a.rd_we = 0; bus_a.rd_addr = 0; bus_a.rd_data = 0; bus_a.rs1_addr = 0; bus_a.rs2_addr = 0;
    bus_a.dbg_addr = 0; bus_a.dbg_wdata = 0; bus_a.dbg_mode = 0; bus_a.dbg_sel = 0; bus_a.clr_req = 0;
    bus_b.rd_we = 0; bus_b.rd_addr = 0; bus_b.rd_data = 0; bus_b.rs1_addr = 0; bus_b.rs2_addr = 0;
    bus_b.dbg_addr = 0; bus_b.dbg_wdata = 0; bus_b.dbg_mode = 0; bus_b.dbg_sel = 0; bus_b.clr_req = 0;
  endtask

  function automatic int dbg_index(input logic [31:0] a);
    logic [31:0] off = a - 32'h4100;
    return (off % 4 == 0 && off / 4 < 32) ? int'(off / 4) : -1;
  endfunction

  task automatic core_write(input logic [4:0] a, input logic [31:0] d);
    bus_a.rd_we = 1; bus_a.rd_addr = a; bus_a.rd_data = d;
    cyc;
    bus_a.rd_we = 0;
    if (a != 0) m[a] = d;
  endtask

  task automatic dbg_access(input logic [31:0] a, input logic [1:0] mode, input logic [31:0] wd,
                            output logic [31:0] rdata, output int lat, output logic ack_after);
    bus_a.dbg_addr = a; bus_a.dbg_mode = mode; bus_a.dbg_wdata = wd; bus_a.dbg_sel = 1;
    lat = 0;
    do begin
      cyc;
      lat++;
    end while (!bus_a.dbg_ack && lat < 100);
    rdata = bus_a.dbg_rdata;
    bus_a.dbg_sel = 0; bus_a.dbg_mode = 0;
    cyc;
    ack_after = bus_a.dbg_ack;
  endtask

  task automatic test_reset;
    idle;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_a.busy !== 0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy); end
    checks++; if (bus_a.dbg_ack !== 0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus_a.dbg_ack); end
    checks++; if (bus_a.dbg_rdata !== 0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus_a.dbg_rdata); end
    checks++; if (bus_b.busy !== 0 || bus_b.dbg_ack !== 0) begin errors++; $display("FAIL reset_b: got busy=%b ack=%b expected 0/0", bus_b.busy, bus_b.dbg_ack); end
    reset = 0;
    for (int i = 1; i < 32; i++) begin
      bus_a.rs1_addr = 5'(i); bus_a.rs2_addr = 5'(32 - i);
      #1;
      checks++; if (bus_a.rs1_data !== 0) begin errors++; $display("FAIL reset_rs1 x%0d: got %h expected 0", i, bus_a.rs1_data); end
      checks++; if (bus_a.rs2_data !== 0) begin errors++; $display("FAIL reset_rs2 x%0d: got %h expected 0", 32 - i, bus_a.rs2_data); end
    end
    foreach (m[i]) m[i] = 0;
  endtask

  task automatic test_bypass;
    bus_a.rd_we = 1; bus_a.rd_addr = 5; bus_a.rd_data = 32'hDEADBEEF; bus_a.rs1_addr = 5; bus_a.rs2_addr = 6;
    #1;
    checks++; if (bus_a.rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_same: got %h expected deadbeef", bus_a.rs1_data); end
    checks++; if (bus_a.rs2_data !== 0) begin errors++; $display("FAIL bypass_other: got %h expected 0", bus_a.rs2_data); end
    cyc;
    bus_a.rd_we = 0; m[5] = 32'hDEADBEEF;
    #1;
    checks++; if (bus_a.rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_next: got %h expected deadbeef", bus_a.rs1_data); end
  endtask

  task automatic test_x0;
    logic [31:0] rd; int lat; logic ack2;
    bus_a.rd_we = 1; bus_a.rd_addr = 0; bus_a.rd_data = 32'h1234; bus_a.rs1_addr = 0;
    #1;
    checks++; if (bus_a.rs1_data !== 0) begin errors++; $display("FAIL x0_same: got %h expected 0", bus_a.rs1_data); end
    cyc;
    bus_a.rd_we = 0;
    #1;
    checks++; if (bus_a.rs1_data !== 0) begin errors++; $display("FAIL x0_next: got %h expected 0", bus_a.rs1_data); end
    dbg_access(32'h4100, DBG_MODE_READ, 0, rd, lat, ack2);
    checks++; if (lat !== 1) begin errors++; $display("FAIL x0_dbg_lat: got %0d expected 1", lat); end
    checks++; if (rd !== 0) begin errors++; $display("FAIL x0_dbg_rdata: got %h expected 0", rd); end
  endtask

  task automatic test_core_random;
    logic we; logic [4:0] wa, r1, r2; logic [31:0] wd, e1, e2;
    repeat (200) begin
      we = 1'($urandom_range(0, 1)); wa = 5'($urandom); wd = $urandom;
      r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom); r2 = 5'($urandom);
      bus_a.rd_we = we; bus_a.rd_addr = wa; bus_a.rd_data = wd; bus_a.rs1_addr = r1; bus_a.rs2_addr = r2;
      #1;
      e1 = r1 == 0 ? 0 : (we && wa == r1) ? wd : m[r1];
      e2 = r2 == 0 ? 0 : (we && wa == r2) ? wd : m[r2];
      checks++; if (bus_a.rs1_data !== e1) begin errors++; $display("FAIL rand_rs1 x%0d: got %h expected %h", r1, bus_a.rs1_data, e1); end
      checks++; if (bus_a.rs2_data !== e2) begin errors++; $display("FAIL rand_rs2 x%0d: got %h expected %h", r2, bus_a.rs2_data, e2); end
      cyc;
      if (we && wa != 0) m[wa] = wd;
    end
    bus_a.rd_we = 0;
  endtask

  task automatic test_dbg_read;
    logic [31:0] rd; int lat; logic ack2;
    logic [31:0] bad [3] = '{32'h4102, 32'h4180, 32'h40FC};
    core_write(1, 7);
    dbg_access(32'h4104, DBG_MODE_READ, 0, rd, lat, ack2);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbgrd_lat: got %0d expected 1", lat); end
    checks++; if (ack2 !== 0) begin errors++; $display("FAIL dbgrd_ack_len: got %b expected 0", ack2); end
    checks++; if (rd !== 7) begin errors++; $display("FAIL dbgrd_x1: got %h expected 7", rd); end
    foreach (bad[k]) begin
      dbg_access(bad[k], DBG_MODE_WRITE, 32'hBAD0BAD0, rd, lat, ack2);
      checks++; if (lat !== 1) begin errors++; $display("FAIL dbg_bad_wr_lat %h: got %0d expected 1", bad[k], lat); end
      dbg_access(bad[k], DBG_MODE_READ, 0, rd, lat, ack2);
      checks++; if (lat !== 1 || rd !== 0) begin errors++; $display("FAIL dbg_bad_rd %h: got lat=%0d rdata=%h expected 1/0", bad[k], lat, rd); end
    end
    for (int i = 0; i < 32; i++) begin
      bus_a.rs1_addr = 5'(i);
      #1;
      checks++; if (bus_a.rs1_data !== m[i]) begin errors++; $display("FAIL dbg_bad_nowrite x%0d: got %h expected %h", i, bus_a.rs1_data, m[i]); end
    end
  endtask

  task automatic test_wr_pend;
    bus_a.dbg_addr = 32'h4128; bus_a.dbg_mode = DBG_MODE_WRITE; bus_a.dbg_wdata = 32'hA5A5; bus_a.dbg_sel = 1;
    bus_a.rd_we = 1; bus_a.rd_addr = 3;
    for (int k = 0; k < 3; k++) begin
      bus_a.rd_data = 32'h100 + 32'(k);
      cyc;
      checks++; if (bus_a.dbg_ack !== 0) begin errors++; $display("FAIL wrpend_noack %0d: got %b expected 0", k, bus_a.dbg_ack); end
    end
    bus_a.rd_we = 0; m[3] = 32'h102;
    cyc;
    checks++; if (bus_a.dbg_ack !== 1) begin errors++; $display("FAIL wrpend_ack: got %b expected 1", bus_a.dbg_ack); end
    bus_a.dbg_sel = 0; bus_a.dbg_mode = 0; m[10] = 32'hA5A5;
    cyc;
    checks++; if (bus_a.dbg_ack !== 0) begin errors++; $display("FAIL wrpend_ack_len: got %b expected 0", bus_a.dbg_ack); end
    bus_a.rs1_addr = 10; bus_a.rs2_addr = 3;
    #1;
    checks++; if (bus_a.rs1_data !== 32'hA5A5) begin errors++; $display("FAIL wrpend_x10: got %h expected a5a5", bus_a.rs1_data); end
    checks++; if (bus_a.rs2_data !== 32'h102) begin errors++; $display("FAIL wrpend_x3: got %h expected 102", bus_a.rs2_data); end
  endtask

  task automatic test_dbg_random;
    logic [31:0] a, wd, rd, last, e; int lat, idx; logic ack2, is_rd;
    dbg_access(32'h4100, DBG_MODE_READ, 0, last, lat, ack2);
    checks++; if (last !== 0) begin errors++; $display("FAIL dbgrand_x0: got %h expected 0", last); end
    repeat (80) begin
      case ($urandom_range(0, 4))
        0: a = 32'h4100 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
        1: a = 32'h4180 + 32'($urandom_range(0, 255)) * 4;
        2: a = 32'h4100 - 32'($urandom_range(1, 64)) * 4;
        default: a = 32'h4100 + 32'($urandom_range(0, 31)) * 4;
      endcase
      is_rd = 1'($urandom_range(0, 1)); wd = $urandom;
      dbg_access(a, is_rd ? DBG_MODE_READ : DBG_MODE_WRITE, wd, rd, lat, ack2);
      idx = dbg_index(a);
      checks++; if (lat !== 1 || ack2 !== 0) begin errors++; $display("FAIL dbgrand_ack %h: got lat=%0d after=%b expected 1/0", a, lat, ack2); end
      if (is_rd) begin
        e = idx < 0 ? 0 : m[idx];
        checks++; if (rd !== e) begin errors++; $display("FAIL dbgrand_rd %h: got %h expected %h", a, rd, e); end
        last = e;
      end else begin
        checks++; if (rd !== last) begin errors++; $display("FAIL dbgrand_hold %h: got %h expected %h", a, rd, last); end
        if (idx > 0) m[idx] = wd;
      end
    end
    for (int i = 0; i < 32; i++) begin
      bus_a.rs1_addr = 5'(i);
      #1;
      checks++; if (bus_a.rs1_data !== m[i]) begin errors++; $display("FAIL dbgrand_reg x%0d: got %h expected %h", i, bus_a.rs1_data, m[i]); end
    end
  endtask

  task automatic test_clear;
    int n;
    for (int i = 1; i < 32; i++) core_write(5'(i), $urandom | 32'h1);
    bus_a.clr_req = 1;
    cyc;
    bus_a.clr_req = 0;
    n = 0;
    while (bus_a.busy && n < 100) begin
      if (n == 0) begin bus_a.rd_we = 1; bus_a.rd_addr = 7; bus_a.rd_data = 32'hFFFF; end
      if (n == 1) bus_a.rd_we = 0;
      if (n == 2) begin bus_a.dbg_addr = 32'h4108; bus_a.dbg_mode = DBG_MODE_READ; bus_a.dbg_sel = 1; end
      checks++; if (bus_a.dbg_ack !== 0) begin errors++; $display("FAIL clr_noack %0d: got %b expected 0", n, bus_a.dbg_ack); end
      cyc;
      n++;
    end
    checks++; if (n !== 31) begin errors++; $display("FAIL clr_busy_len: got %0d expected 31", n); end
    checks++; if (bus_a.dbg_ack !== 0) begin errors++; $display("FAIL clr_end_ack: got %b expected 0", bus_a.dbg_ack); end
    cyc;
    checks++; if (bus_a.dbg_ack !== 1 || bus_a.dbg_rdata !== 0) begin errors++; $display("FAIL clr_dbg_after: got ack=%b rdata=%h expected 1/0", bus_a.dbg_ack, bus_a.dbg_rdata); end
    bus_a.dbg_sel = 0; bus_a.dbg_mode = 0;
    cyc;
    foreach (m[i]) m[i] = 0;
    for (int i = 0; i < 32; i++) begin
      bus_a.rs1_addr = 5'(i);
      #1;
      checks++; if (bus_a.rs1_data !== 0) begin errors++; $display("FAIL clr_reg x%0d: got %h expected 0", i, bus_a.rs1_data); end
    end
  endtask

  task automatic test_clear_held;
    int n;
    core_write(9, 32'h99);
    bus_a.clr_req = 1;
    cyc;
    n = 0;
    while (bus_a.busy && n < 100) begin cyc; n++; end
    checks++; if (n !== 31) begin errors++; $display("FAIL clrheld_len1: got %0d expected 31", n); end
    cyc;
    checks++; if (bus_a.busy !== 1) begin errors++; $display("FAIL clrheld_restart: got %b expected 1", bus_a.busy); end
    bus_a.clr_req = 0;
    n = 0;
    while (bus_a.busy && n < 100) begin cyc; n++; end
    checks++; if (n !== 31) begin errors++; $display("FAIL clrheld_len2: got %0d expected 31", n); end
    m[9] = 0;
    bus_a.rs1_addr = 9;
    #1;
    checks++; if (bus_a.rs1_data !== 0) begin errors++; $display("FAIL clrheld_x9: got %h expected 0", bus_a.rs1_data); end
  endtask

  task automatic test_async_reset;
    core_write(4, 32'h44);
    core_write(20, 32'h2020);
    bus_a.rd_we = 1; bus_a.rd_addr = 4; bus_a.rd_data = 32'h45;
    bus_a.dbg_addr = 32'h4114; bus_a.dbg_mode = DBG_MODE_WRITE; bus_a.dbg_wdata = 32'h55; bus_a.dbg_sel = 1;
    cyc;
    cyc;
    bus_a.rd_we = 0; bus_a.rs1_addr = 4;
    #1 reset = 1;
    #1;
    checks++; if (bus_a.dbg_ack !== 0 || bus_a.busy !== 0) begin errors++; $display("FAIL arst_pend_flags: got ack=%b busy=%b expected 0/0", bus_a.dbg_ack, bus_a.busy); end
    checks++; if (bus_a.rs1_data !== 0) begin errors++; $display("FAIL arst_pend_x4: got %h expected 0", bus_a.rs1_data); end
    bus_a.dbg_sel = 0; bus_a.dbg_mode = 0;
    #1 reset = 0;
    foreach (m[i]) m[i] = 0;
    for (int k = 0; k < 3; k++) begin
      cyc;
      checks++; if (bus_a.dbg_ack !== 0) begin errors++; $display("FAIL arst_pend_noack %0d: got %b expected 0", k, bus_a.dbg_ack); end
    end
    bus_a.rs1_addr = 5;
    #1;
    checks++; if (bus_a.rs1_data !== 0) begin errors++; $display("FAIL arst_pend_x5: got %h expected 0", bus_a.rs1_data); end
    core_write(20, 32'h2020);
    bus_a.clr_req = 1;
    cyc;
    bus_a.clr_req = 0;
    repeat (3) cyc;
    checks++; if (bus_a.busy !== 1) begin errors++; $display("FAIL arst_clr_busy: got %b expected 1", bus_a.busy); end
    bus_a.rs1_addr = 20;
    #1 reset = 1;
    #1;
    checks++; if (bus_a.busy !== 0 || bus_a.rs1_data !== 0) begin errors++; $display("FAIL arst_clr: got busy=%b x20=%h expected 0/0", bus_a.busy, bus_a.rs1_data); end
    #1 reset = 0;
    m[20] = 0;
    cyc;
    checks++; if (bus_a.busy !== 0) begin errors++; $display("FAIL arst_clr_stay: got %b expected 0", bus_a.busy); end
  endtask

  task automatic test_cfg16;
    int n;
    bus_b.rd_we = 1; bus_b.rd_addr = 5; bus_b.rd_data = 32'hDEADBEEF; bus_b.rs1_addr = 5;
    #1;
    checks++; if (bus_b.rs1_data !== 0) begin errors++; $display("FAIL b_nobypass: got %h expected 0", bus_b.rs1_data); end
    cyc;
    bus_b.rd_we = 0;
    #1;
    checks++; if (bus_b.rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL b_x5_next: got %h expected deadbeef", bus_b.rs1_data); end
    bus_b.rd_we = 1; bus_b.rd_addr = 20; bus_b.rd_data = 32'h1;
    cyc;
    bus_b.rd_we = 0; bus_b.rs1_addr = 20; bus_b.rs2_addr = 4;
    #1;
    checks++; if (bus_b.rs1_data !== 0 || bus_b.rs2_data !== 0) begin errors++; $display("FAIL b_oob_write: got x20=%h x4=%h expected 0/0", bus_b.rs1_data, bus_b.rs2_data); end
    bus_b.dbg_addr = 32'h4140; bus_b.dbg_mode = DBG_MODE_READ; bus_b.dbg_sel = 1;
    cyc;
    checks++; if (bus_b.dbg_ack !== 1 || bus_b.dbg_rdata !== 0) begin errors++; $display("FAIL b_dbg_oob: got ack=%b rdata=%h expected 1/0", bus_b.dbg_ack, bus_b.dbg_rdata); end
    bus_b.dbg_sel = 0;
    cyc;
    bus_b.dbg_addr = 32'h413C; bus_b.dbg_mode = DBG_MODE_WRITE; bus_b.dbg_wdata = 32'h55; bus_b.dbg_sel = 1;
    cyc;
    checks++; if (bus_b.dbg_ack !== 1) begin errors++; $display("FAIL b_dbg_wr_ack: got %b expected 1", bus_b.dbg_ack); end
    bus_b.dbg_sel = 0; bus_b.dbg_mode = 0;
    cyc;
    bus_b.rs1_addr = 15;
    #1;
    checks++; if (bus_b.rs1_data !== 32'h55) begin errors++; $display("FAIL b_x15: got %h expected 55", bus_b.rs1_data); end
    bus_b.clr_req = 1;
    cyc;
    bus_b.clr_req = 0;
    n = 0;
    while (bus_b.busy && n < 100) begin cyc; n++; end
    checks++; if (n !== 15) begin errors++; $display("FAIL b_clr_len: got %0d expected 15", n); end
    bus_b.rs2_addr = 5;
    #1;
    checks++; if (bus_b.rs1_data !== 0 || bus_b.rs2_data !== 0) begin errors++; $display("FAIL b_clr_regs: got x15=%h x5=%h expected 0/0", bus_b.rs1_data, bus_b.rs2_data); end
  endtask

  initial begin
    test_reset;
    test_bypass;
    test_x0;
    test_core_random;
    test_dbg_read;
    test_wr_pend;
    test_dbg_random;
    test_clear;
    test_clear_held;
    test_async_reset;
    test_cfg16;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
